// File: rtl/slot_alloc24.sv
// slot_alloc24: 24-entry free-slot allocator.
// The lowest free slot is granted on request. Slots are returned on free.
// Every output is a register, so no input reaches an output combinationally.

// flo24: index of the lowest set bit in a 24-bit vector, or 31 if the vector is empty.
module flo24 (
   input  logic [23:0] vec_i,
   output logic [4:0]  idx_o
);
   // Scan from the top down so that the lowest set bit is the last one written.
   always_comb begin
      idx_o = 5'd31;
      for (int i = 23; i >= 0; i--) begin
         if (vec_i[i]) idx_o = 5'(i);
      end
   end
endmodule

module slot_alloc24 (
   input  logic        clk,
   input  logic        rst,
   input  logic        alloc_req,
   input  logic        free_v,
   input  logic [4:0]  free_tag,
   input  logic        flush,
   output logic        alloc_ack,
   output logic [4:0]  alloc_tag,
   output logic [23:0] free_map,
   output logic [4:0]  free_cnt,
   output logic        exhausted,
   output logic        all_free,
   output logic        err
);
   localparam logic [4:0] NONE = 5'd31;

   logic [23:0] free_map_q, free_map_d;
   logic [4:0]  free_cnt_q, free_cnt_d;
   logic        exhausted_q, exhausted_d;
   logic        all_free_q, all_free_d;
   logic        alloc_ack_q, alloc_ack_d;
   logic [4:0]  alloc_tag_q, alloc_tag_d;
   logic        err_q, err_d;

   logic [4:0]  lowest;
   logic [31:0] map_ext;
   logic        grant, free_ok;
   logic [23:0] grant_mask, free_mask;

   // The lowest free slot is taken from the registered map. A slot freed in
   // this cycle can therefore only be granted from the next cycle onward.
   flo24 u_flo (.vec_i(free_map_q), .idx_o(lowest));

   // Zero-extend the map so that tags 24..31 read back as "not free" without
   // an out-of-range index.
   assign map_ext = {8'h00, free_map_q};

   // Grant and free decoding. A legal free can never target the granted slot,
   // because the granted slot is free before the edge.
   always_comb begin
      grant      = alloc_req && (lowest != NONE);
      free_ok    = free_v && (free_tag < 5'd24) && !map_ext[free_tag];
      grant_mask = grant   ? (24'd1 << lowest)   : 24'd0;
      free_mask  = free_ok ? (24'd1 << free_tag) : 24'd0;
   end

   // Next state. Flush overrides both grant and free.
   always_comb begin
      free_map_d  = (free_map_q & ~grant_mask) | free_mask;
      free_cnt_d  = free_cnt_q;
      unique case ({grant, free_ok})
         2'b10:   free_cnt_d = free_cnt_q - 5'd1;
         2'b01:   free_cnt_d = free_cnt_q + 5'd1;
         default: free_cnt_d = free_cnt_q;
      endcase
      alloc_ack_d = grant;
      alloc_tag_d = grant ? lowest : NONE;
      err_d       = free_v && !free_ok;
      if (flush) begin
         free_map_d  = 24'hFFFFFF;
         free_cnt_d  = 5'd24;
         alloc_ack_d = 1'b0;
         alloc_tag_d = NONE;
         err_d       = 1'b0;
      end
      exhausted_d = (free_cnt_d == 5'd0);
      all_free_d  = (free_cnt_d == 5'd24);
   end

   // State registers with synchronous reset. Reset drops any grant in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         free_map_q  <= 24'hFFFFFF;
         free_cnt_q  <= 5'd24;
         exhausted_q <= 1'b0;
         all_free_q  <= 1'b1;
         alloc_ack_q <= 1'b0;
         alloc_tag_q <= NONE;
         err_q       <= 1'b0;
      end else begin
         free_map_q  <= free_map_d;
         free_cnt_q  <= free_cnt_d;
         exhausted_q <= exhausted_d;
         all_free_q  <= all_free_d;
         alloc_ack_q <= alloc_ack_d;
         alloc_tag_q <= alloc_tag_d;
         err_q       <= err_d;
      end
   end

   assign free_map  = free_map_q;
   assign free_cnt  = free_cnt_q;
   assign exhausted = exhausted_q;
   assign all_free  = all_free_q;
   assign alloc_ack = alloc_ack_q;
   assign alloc_tag = alloc_tag_q;
   assign err       = err_q;
endmodule

// File: tb/tb_slot_alloc24.sv
// Directed and random checks for slot_alloc24.
module tb_slot_alloc24;
   logic        clk = 1'b0;
   logic        rst, alloc_req, free_v, flush;
   logic [4:0]  free_tag;
   logic        alloc_ack, exhausted, all_free, err;
   logic [4:0]  alloc_tag, free_cnt;
   logic [23:0] free_map;

   int checks   = 0;
   int failures = 0;

   slot_alloc24 dut (
      .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_v(free_v),
      .free_tag(free_tag), .flush(flush), .alloc_ack(alloc_ack),
      .alloc_tag(alloc_tag), .free_map(free_map), .free_cnt(free_cnt),
      .exhausted(exhausted), .all_free(all_free), .err(err)
   );

   always #5 clk = ~clk;

   // Every cycle: the count equals the popcount of the map, and both flags track the count.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (free_cnt !== 5'($countones(free_map)) || exhausted !== (free_cnt == 5'd0)
             || all_free !== (free_cnt == 5'd24)) begin
            failures++;
            $display("FAIL invariant: cnt=%0d map=%h exh=%b allf=%b", free_cnt, free_map, exhausted, all_free);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; alloc_req = 1'b1; free_v = 1'b0; free_tag = 5'd0; flush = 1'b0;
      tick();
      rst = 1'b0; alloc_req = 1'b0;
      checks++;
      if (free_map !== 24'hFFFFFF || free_cnt !== 5'd24 || all_free !== 1'b1 || exhausted !== 1'b0
          || alloc_ack !== 1'b0 || alloc_tag !== 5'd31 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset: map=%h cnt=%0d allf=%b exh=%b ack=%b tag=%0d err=%b",
                  free_map, free_cnt, all_free, exhausted, alloc_ack, alloc_tag, err);
      end
   endtask

   task automatic test_ascending();
      alloc_req = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         checks++;
         if (alloc_ack !== 1'b1 || alloc_tag !== 5'(i) || free_cnt !== 5'(23 - i)) begin
            failures++;
            $display("FAIL ascending[%0d]: ack=%b tag=%0d cnt=%0d want tag=%0d cnt=%0d",
                     i, alloc_ack, alloc_tag, free_cnt, i, 23 - i);
         end
      end
      checks++;
      if (exhausted !== 1'b1 || free_map !== 24'h0) begin
         failures++;
         $display("FAIL exhaust_flag: exh=%b map=%h want 1/000000", exhausted, free_map);
      end
      tick();
      checks++;
      if (alloc_ack !== 1'b0 || alloc_tag !== 5'd31) begin
         failures++;
         $display("FAIL refusal: ack=%b tag=%0d want 0/31", alloc_ack, alloc_tag);
      end
      alloc_req = 1'b0;
   endtask

   task automatic test_reuse();
      free_v = 1'b1; free_tag = 5'd17; tick();
      free_tag = 5'd5; tick();
      free_v = 1'b0;
      checks++;
      if (free_map !== 24'h020020 || free_cnt !== 5'd2 || err !== 1'b0) begin
         failures++;
         $display("FAIL reuse_frees: map=%h cnt=%0d err=%b want 020020/2/0", free_map, free_cnt, err);
      end
      alloc_req = 1'b1; tick();
      checks++;
      if (alloc_ack !== 1'b1 || alloc_tag !== 5'd5) begin
         failures++;
         $display("FAIL reuse_first: ack=%b tag=%0d want 1/5", alloc_ack, alloc_tag);
      end
      tick();
      checks++;
      if (alloc_ack !== 1'b1 || alloc_tag !== 5'd17 || free_cnt !== 5'd0 || exhausted !== 1'b1) begin
         failures++;
         $display("FAIL reuse_second: ack=%b tag=%0d cnt=%0d want 1/17/0", alloc_ack, alloc_tag, free_cnt);
      end
      alloc_req = 1'b0; tick();
      checks++;
      if (alloc_ack !== 1'b0) begin
         failures++;
         $display("FAIL ack_pulse: ack=%b want 0", alloc_ack);
      end
   endtask

   task automatic test_same_cycle();
      free_v = 1'b1; free_tag = 5'd9; tick();
      alloc_req = 1'b1; free_tag = 5'd3; tick();
      free_v = 1'b0;
      checks++;
      if (alloc_ack !== 1'b1 || alloc_tag !== 5'd9 || free_cnt !== 5'd1 || free_map !== 24'h000008) begin
         failures++;
         $display("FAIL same_cycle: ack=%b tag=%0d cnt=%0d map=%h want 1/9/1/000008",
                  alloc_ack, alloc_tag, free_cnt, free_map);
      end
      tick();
      checks++;
      if (alloc_ack !== 1'b1 || alloc_tag !== 5'd3 || free_cnt !== 5'd0) begin
         failures++;
         $display("FAIL same_cycle_next: ack=%b tag=%0d cnt=%0d want 1/3/0", alloc_ack, alloc_tag, free_cnt);
      end
      alloc_req = 1'b0; tick();
   endtask

   task automatic test_illegal();
      free_v = 1'b1; free_tag = 5'd4; tick();
      checks++;
      if (err !== 1'b0 || free_map !== 24'h000010) begin
         failures++;
         $display("FAIL legal_free: err=%b map=%h want 0/000010", err, free_map);
      end
      tick();
      checks++;
      if (err !== 1'b1 || free_map !== 24'h000010 || free_cnt !== 5'd1) begin
         failures++;
         $display("FAIL double_free: err=%b map=%h cnt=%0d want 1/000010/1", err, free_map, free_cnt);
      end
      free_tag = 5'd24; tick();
      checks++;
      if (err !== 1'b1 || free_map !== 24'h000010 || free_cnt !== 5'd1) begin
         failures++;
         $display("FAIL free_24: err=%b map=%h cnt=%0d want 1/000010/1", err, free_map, free_cnt);
      end
      free_tag = 5'd31; tick();
      checks++;
      if (err !== 1'b1 || free_map !== 24'h000010) begin
         failures++;
         $display("FAIL free_31: err=%b map=%h want 1/000010", err, free_map);
      end
      free_v = 1'b0; tick();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_pulse: err=%b want 0", err);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1; alloc_req = 1'b1; free_v = 1'b1; free_tag = 5'd4; tick();
      flush = 1'b0; alloc_req = 1'b0; free_v = 1'b0;
      checks++;
      if (free_map !== 24'hFFFFFF || free_cnt !== 5'd24 || alloc_ack !== 1'b0 || alloc_tag !== 5'd31
          || err !== 1'b0 || all_free !== 1'b1) begin
         failures++;
         $display("FAIL flush: map=%h cnt=%0d ack=%b tag=%0d err=%b", free_map, free_cnt, alloc_ack, alloc_tag, err);
      end
   endtask

   task automatic test_reset_priority();
      alloc_req = 1'b1; tick(); tick();
      checks++;
      if (alloc_tag !== 5'd1 || free_cnt !== 5'd22) begin
         failures++;
         $display("FAIL pre_reset: tag=%0d cnt=%0d want 1/22", alloc_tag, free_cnt);
      end
      rst = 1'b1; free_v = 1'b1; free_tag = 5'd0; tick();
      rst = 1'b0; alloc_req = 1'b0; free_v = 1'b0;
      checks++;
      if (alloc_ack !== 1'b0 || alloc_tag !== 5'd31 || free_map !== 24'hFFFFFF || free_cnt !== 5'd24
          || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_prio: ack=%b tag=%0d map=%h cnt=%0d err=%b",
                  alloc_ack, alloc_tag, free_map, free_cnt, err);
      end
   endtask

   task automatic test_soak();
      logic [23:0] m, held;
      logic [4:0]  lo, ft, etag;
      logic        rq, fv, fl, legal, eack, eerr;
      m = 24'hFFFFFF; held = 24'h0;
      for (int c = 0; c < 10000; c++) begin
         rq = ($urandom_range(0, 99) < 55);
         fv = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 999) < 4);
         ft = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
         lo = 5'd31;
         for (int i = 23; i >= 0; i--) if (m[i]) lo = 5'(i);
         legal = fv && (ft < 5'd24) && ((ft < 5'd24) ? !m[ft] : 1'b0);
         eack  = rq && (lo != 5'd31) && !fl;
         etag  = eack ? lo : 5'd31;
         eerr  = fv && !legal && !fl;
         if (fl) begin
            m = 24'hFFFFFF; held = 24'h0;
         end else begin
            if (eack) m[lo] = 1'b0;
            if (legal) begin m[ft] = 1'b1; held[ft] = 1'b0; end
         end
         alloc_req = rq; free_v = fv; free_tag = ft; flush = fl;
         tick();
         checks++;
         if (alloc_ack !== eack || alloc_tag !== etag || err !== eerr || free_map !== m
             || free_cnt !== 5'($countones(m))) begin
            failures++;
            $display("FAIL soak[%0d]: ack=%b/%b tag=%0d/%0d err=%b/%b map=%h/%h cnt=%0d",
                     c, alloc_ack, eack, alloc_tag, etag, err, eerr, free_map, m, free_cnt);
         end
         if (alloc_ack === 1'b1 && alloc_tag < 5'd24) begin
            checks++;
            if (held[alloc_tag] !== 1'b0) begin
               failures++;
               $display("FAIL soak_dup[%0d]: tag %0d granted while outstanding", c, alloc_tag);
            end
            held[alloc_tag] = 1'b1;
         end
      end
      alloc_req = 1'b0; free_v = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; alloc_req = 1'b0; free_v = 1'b0; free_tag = 5'd0; flush = 1'b0;
      test_reset();
      test_ascending();
      test_reuse();
      test_same_cycle();
      test_illegal();
      test_flush();
      test_reset_priority();
      test_soak();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/slot_alloc24.md
# slot_alloc24

24-entry free-slot allocator. Holds a free bitmap, grants the lowest-numbered free slot on request via the 24-bit find-lowest-one encoder (`flo24`), and returns slots on free. It sits between the issue/tag logic and the 24-entry buffer it manages. Every grant, free count and status flag is registered.

## Interface
- No parameters. Slot count is fixed at 24, with tags 0-23. Tag value 31 means "none".
- `clk  in  1`  clock; all state updates on the rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `alloc_req  in  1`  request one slot this cycle; level-sensitive.
- `free_v  in  1`  return slot `free_tag` this cycle.
- `free_tag  in  5`  tag being returned.
- `flush  in  1`  mark all 24 slots free.
- `alloc_ack  out  1`  one-cycle pulse; `alloc_tag` is valid.
- `alloc_tag  out  5`  granted tag (0-23); 31 when no grant.
- `free_map  out  24`  current bitmap; 1 = free.
- `free_cnt  out  5`  number of free slots, 0-24.
- `exhausted  out  1`  `free_cnt == 0`.
- `all_free  out  1`  `free_cnt == 24`.
- `err  out  1`  one-cycle pulse on an illegal free.

## Operation
- The lowest free index is computed combinationally from the registered `free_map` with one `flo24` instance. Its result is 31 when the map is zero.
- **Grant.** If `alloc_req` and the lowest index is not 31, then at the edge:
  - `alloc_ack` ← 1 and `alloc_tag` ← index;
  - that bit of `free_map` is cleared;
  - `free_cnt` is decremented.
- **Refusal.** If `alloc_req` and the map is zero, then `alloc_ack` ← 0 and `alloc_tag` ← 31. The request is not queued; the requester holds `alloc_req` until it sees `alloc_ack`.
- `alloc_req` held high yields one grant per cycle, in ascending free order.
- **Free.** If `free_v` and `free_tag` < 24 and the bit is 0:
  - the bit is set;
  - `free_cnt` is incremented.
- **Illegal free.** If `free_v` and either `free_tag` ≥ 24 or the bit is already 1:
  - `err` ← 1 for one cycle;
  - the map and count are unchanged.
- **Simultaneous grant and free.** Both apply at the same edge. The grant uses the pre-free map, so a slot freed this cycle is not grantable until the next cycle. Net `free_cnt` change is 0. The freed tag can never equal the granted tag, because the granted slot was free before the edge.
- **Flush.** Overrides grant and free in the same cycle:
  - `free_map` ← 24'hFFFFFF, `free_cnt` ← 24;
  - `alloc_ack` ← 0, `alloc_tag` ← 31, `err` ← 0.
- **Status flags.** `exhausted` and `all_free` are registered alongside `free_cnt` and always match it.
- **Invariant.** `free_cnt` always equals the popcount of `free_map`. The bench checks this every cycle.

## Timing
- **Reset values:** `free_map` = 24'hFFFFFF, `free_cnt` = 24, `all_free` = 1, `exhausted` = 0, `alloc_ack` = 0, `alloc_tag` = 31, `err` = 0.
- Reset overrides all inputs and takes effect at the edge where `rst` = 1. Grants in flight are dropped, and no `alloc_ack` is issued on the cycle after the reset edge.
- **Grant latency:** 1 cycle. `alloc_req` is sampled at edge N, and `alloc_ack`/`alloc_tag` are valid for the cycle after edge N.
- **Free latency:** 1 cycle. A free sampled at edge N is visible in `free_map`/`free_cnt` after edge N and is grantable from edge N+1.
- **Pulse widths:** `alloc_ack` and `err` are high for exactly one cycle per event.
- **No combinational paths:** no combinational path runs from any input to any output.
- **Exhaustion boundary:** the 24th consecutive grant drives `exhausted` high in the same cycle as its `alloc_ack`. The next request then returns `alloc_ack` = 0 and `alloc_tag` = 31.

## Test plan
- **Ascending grants.** After reset, hold `alloc_req` for 25 cycles. Expect:
  - tags 0,1,…,23 on consecutive cycles;
  - `exhausted` = 1 and `free_cnt` = 0 after the 24th grant;
  - the 25th cycle gives `alloc_ack` = 0, `alloc_tag` = 31.
- **Lowest free is reused.** From the exhausted state, free tags 17 then 5 on successive cycles, then request twice. Expect grants 5 then 17, and `free_cnt` returning to 0.
- **Grant and free in the same cycle.** With only tag 9 free, assert `alloc_req` and free tag 3 in the same cycle. Expect:
  - that grant is tag 9;
  - `free_cnt` unchanged at 1;
  - the next request gets tag 3.
- **Illegal frees.** Free tag 4 while it is already free, then free tag 24. Expect an `err` pulse on each and `free_map` unchanged. Free tag 31 also pulses `err`.
- **Flush and reset priority.**
  - Assert `flush` together with `alloc_req` and `free_v`. Expect `free_map` = FFFFFF, `free_cnt` = 24, `alloc_ack` = 0.
  - Assert `rst` during back-to-back grants. Expect the reset values on the next cycle and no `alloc_ack`.
- **Random soak.** Run 10k random req/free/flush cycles against a bitmap model. Check:
  - the `free_cnt` = popcount invariant holds every cycle;
  - granted tags never duplicate while outstanding.
